conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
Downstream consumer of the BRAM read stage. Takes the kernel register (9 x 32-bit words) and the 8-bit pixel stream (pixel/pixel_valid), and performs a 3x3 valid-mode (no padding) convolution over a raster-ordered image. Two internal line buffers hold the previous rows. Emits one signed result per valid window position, plus a frame-done pulse to the result writer/PS interrupt logic.

Parameters:
DATA_WIDTH, 32, width of each kernel word
PIXEL_SIZE, 8, unsigned pixel width
KERNEL_SIZE, 9, number of kernel words; fixed 3x3, other values unsupported
COEF_WIDTH, 8, signed coefficient taken from bits [COEF_WIDTH-1:0] of each kernel word
IMAGE_WIDTH, 28, pixels per row (>=3)
IMAGE_HEIGHT, 28, rows per frame (>=3)
ACC_WIDTH, 20, signed result width; must be >= PIXEL_SIZE+COEF_WIDTH+4

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
kernel  in  KERNEL_SIZE x DATA_WIDTH  kernel words; word k = row k/3, column k%3 (word 0 top-left)
pixel  in  PIXEL_SIZE  incoming pixel, raster order
pixel_valid  in  1  pixel accepted on each clk edge where high; no backpressure
clear  in  1  synchronous frame abort/restart
result_data  out  ACC_WIDTH  signed convolution sum
result_valid  out  1  result_data valid this cycle
frame_done  out  1  one-cycle pulse coincident with last result of frame
busy  out  1  high from first accepted pixel until frame_done

Behaviour:
- Reset: result_data=0, result_valid=0, frame_done=0, busy=0; col/row counters=0; pipeline valids=0; line buffer/window contents don't-care (never emitted before refill).
- Counters: col 0..IMAGE_WIDTH-1, row 0..IMAGE_HEIGHT-1, advance only on accepted pixel. col wraps to 0 and row increments; at (row=H-1,col=W-1) both wrap to 0 and next pixel starts a new frame.
- Kernel latch: coefficients sampled into internal registers on acceptance of pixel (0,0); held constant for the whole frame. Changes to kernel mid-frame have no effect until next frame.
- Window: on each accepted pixel, 3x3 window shifts left one column; new right column = {line_buf1[col], line_buf0[col], pixel} (top to bottom); line buffers updated in the same edge (buf1<=buf0[col], buf0<=pixel).
- Window valid when accepted pixel has row>=2 and col>=2; window then covers rows row-2..row, cols col-2..col.
- Arithmetic: pixel zero-extended, coefficient sign-extended; 9 products summed at ACC_WIDTH; no saturation, no overflow possible at defaults.
- Pipeline: stage 1 = window register (edge N, pixel accepted), stage 2 = products+sum registered (edge N+1), output register (edge N+2). result_valid high exactly one cycle, 2 cycles after the accepting edge; latency independent of pixel_valid gaps. result_data holds its last value while result_valid low.
- Results per frame: (W-2)*(H-2) = 676 at defaults, in raster order.
- frame_done: asserted with the result of window (H-1,W-1); busy falls the cycle after.
- busy rises on the edge accepting pixel (0,0).
- clear: counters to 0, pipeline valids to 0, busy to 0, any in-flight results discarded (no result_valid/frame_done after clear edge). clear has priority over pixel_valid in the same cycle (that pixel dropped).
- reset mid-frame: identical to clear but asynchronous; next accepted pixel is (0,0).
- Back-to-back frames with no gap: supported; frame N's last two pipeline outputs overlap frame N+1 pixels (0,0),(0,1) without corruption.

Test Plan:
- Identity kernel (word 4 = 1, others 0), pixels p=(r*28+c) mod 256 continuous -> 676 results, result k at window (r,c) equals ((r-1)*28+c-1) mod 256; frame_done with 676th.
- All-ones kernel, constant pixel 10 -> every result 90; first result_valid 2 cycles after 59th accepted pixel (row 2, col 2).
- All coefficients 8'h80 (-128), pixels 255 -> every result -293760 (20'hB8480).
- Identity kernel, pixel_valid random 50% duty -> same result sequence as continuous case; each result exactly 2 cycles after its accepting pixel.
- Kernel changed mid-frame -> no effect on current frame; next frame uses new kernel.
- clear asserted at pixel 300 (and separately reset at pixel 300), then full frame -> no results after abort until new frame; exactly 676 correct results and one frame_done.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution over a raster-ordered 8-bit image.
// Two line buffers feed a 3x3 window; result appears two edges after the accepting pixel.
module conv3x3_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIXEL_SIZE   = 8,
  parameter int KERNEL_SIZE  = 9,
  parameter int COEF_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int ACC_WIDTH    = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] kernel,
  input  logic [PIXEL_SIZE-1:0]             pixel,
  input  logic                              pixel_valid,
  input  logic                              clear,
  output logic [ACC_WIDTH-1:0]              result_data,
  output logic                              result_valid,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int CW     = $clog2(IMAGE_WIDTH);
  localparam int RW     = $clog2(IMAGE_HEIGHT);
  localparam int PROD_W = PIXEL_SIZE + COEF_WIDTH + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept;
  logic frame_start;
  logic win_valid;
  logic win_last;

  logic signed [COEF_WIDTH-1:0] coef [KERNEL_SIZE];
  logic [PIXEL_SIZE-1:0] line_buf0 [IMAGE_WIDTH];
  logic [PIXEL_SIZE-1:0] line_buf1 [IMAGE_WIDTH];
  logic [PIXEL_SIZE-1:0] win [3][3];

  logic                 v1, l1, v2, l2;
  logic [ACC_WIDTH-1:0] sum_c, sum_q;
  logic [KERNEL_SIZE-1:0] unused_kernel_hi;

  // clear wins over pixel_valid: the pixel presented with clear is dropped
  assign accept      = pixel_valid && !clear;
  assign frame_start = accept && (col == '0) && (row == '0);
  assign win_valid   = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign win_last    = accept && (row == ROW_LAST) && (col == COL_LAST);

  // Only the low COEF_WIDTH bits of each kernel word carry the coefficient.
  always_comb begin
    for (int k = 0; k < KERNEL_SIZE; k++)
      unused_kernel_hi[k] = ^kernel[k*DATA_WIDTH+COEF_WIDTH +: DATA_WIDTH-COEF_WIDTH];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking here would let stage 2 see this edge's freshly shifted window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      v1           <= 1'b0;
      l1           <= 1'b0;
      v2           <= 1'b0;
      l2           <= 1'b0;
      sum_q        <= '0;
      result_data  <= '0;
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      for (int k = 0; k < KERNEL_SIZE; k++) coef[k] <= '0;
    end else if (clear) begin
      col          <= '0;
      row          <= '0;
      v1           <= 1'b0;
      l1           <= 1'b0;
      v2           <= 1'b0;
      l2           <= 1'b0;
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      v1           <= win_valid;
      l1           <= win_last;
      v2           <= v1;
      l2           <= l1;
      sum_q        <= sum_c;
      result_valid <= v2;
      frame_done   <= v2 && l2;
      if (v2) result_data <= sum_q;

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // Coefficients are frozen for the frame; stage 2 of the previous frame
      // still reads the old copy on this same edge.
      if (frame_start) begin
        for (int k = 0; k < KERNEL_SIZE; k++)
          coef[k] <= kernel[k*DATA_WIDTH +: COEF_WIDTH];
      end

      // A frame that started back-to-back keeps busy high past the old frame_done
      if (frame_start)
        busy <= 1'b1;
      else if (frame_done && (col == '0) && (row == '0))
        busy <= 1'b0;
    end
  end

  // NOTE: line buffers and window are storage, not control; they are refilled
  // before any window they hold can be marked valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]      <= line_buf1[col];
      win[1][2]      <= line_buf0[col];
      win[2][2]      <= pixel;
      line_buf1[col] <= line_buf0[col];
      line_buf0[col] <= pixel;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    logic signed [PROD_W-1:0] px_ext;
    logic signed [PROD_W-1:0] cf_ext;
    logic signed [PROD_W-1:0] prod;
    sum_c  = '0;
    px_ext = '0;
    cf_ext = '0;
    prod   = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px_ext = {{(PROD_W-PIXEL_SIZE){1'b0}}, win[i][j]};
        cf_ext = {{(PROD_W-COEF_WIDTH){coef[i*3+j][COEF_WIDTH-1]}}, coef[i*3+j]};
        prod   = px_ext * cf_ext;
        sum_c  = sum_c + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised bench for conv3x3_stream against a frame-level reference model
// that convolves a stored image with the kernel latched at each frame start.
module tb_conv3x3_stream;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int DW = 32;
  localparam int AW = 20;

  logic              clk;
  logic              reset;
  logic [9*DW-1:0]   kernel;
  logic [7:0]        pixel;
  logic              pixel_valid;
  logic              clear;
  logic [AW-1:0]     result_data;
  logic              result_valid;
  logic              frame_done;
  logic              busy;

  conv3x3_stream dut (
    .clk          (clk),
    .reset        (reset),
    .kernel       (kernel),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid),
    .clear        (clear),
    .result_data  (result_data),
    .result_valid (result_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     val;
    bit     last;
    longint due;
  } exp_t;

  exp_t          exp_q[$];
  int            img [H][W];
  int            mk [9];
  int            m_row, m_col;
  bit            busy_m, fd_prev;
  logic [AW-1:0] last_data;
  longint        cyc;
  int            n_checks, n_errors;
  int            n_res, n_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: store the frame, convolve each complete window with plain arithmetic.
  task automatic model_edge(input bit v, input logic [7:0] p, input bit clr);
    int s;
    if (clr) begin
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      busy_m = 0;
      return;
    end
    if (v && m_row == 0 && m_col == 0) busy_m = 1;
    else if (fd_prev && m_row == 0 && m_col == 0) busy_m = 0;
    if (!v) return;
    if (m_row == 0 && m_col == 0)
      for (int k = 0; k < 9; k++) mk[k] = int'($signed(kernel[k*DW +: 8]));
    img[m_row][m_col] = int'(p);
    if (m_row >= 2 && m_col >= 2) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += img[m_row-2+i][m_col-2+j] * mk[i*3+j];
      exp_q.push_back('{val: s, last: (m_row == H-1 && m_col == W-1), due: cyc + 2});
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic compare();
    exp_t e;
    logic [31:0] ev;
    if (result_valid === 1'b1) n_res++;
    if (frame_done === 1'b1) n_done++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e  = exp_q.pop_front();
      ev = e.val;
      check("result_valid", 32'(result_valid), 32'd1);
      check("result_data", 32'(result_data), 32'(ev[AW-1:0]));
      check("frame_done", 32'(frame_done), 32'(e.last));
      last_data = ev[AW-1:0];
      fd_prev   = e.last;
    end else begin
      check("idle_valid", 32'(result_valid), 32'd0);
      check("idle_frame_done", 32'(frame_done), 32'd0);
      check("data_hold", 32'(result_data), 32'(last_data));
      fd_prev = 1'b0;
    end
    check("busy", 32'(busy), 32'(busy_m));
  endtask

  task automatic tick(input bit v, input logic [7:0] p, input bit clr);
    pixel_valid = v;
    pixel       = p;
    clear       = clr;
    @(posedge clk);
    cyc++;
    model_edge(v, p, clr);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pixel_valid = 1'b0;
    clear       = 1'b0;
    #1;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    busy_m    = 1'b0;
    fd_prev   = 1'b0;
    last_data = '0;
    check("rst_result_data", 32'(result_data), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // kmode: 0 identity, 1 all ones, 2 all -128, 3 random; upper word bits are junk
  task automatic set_kernel(input int kmode);
    logic [7:0] c;
    for (int k = 0; k < 9; k++) begin
      case (kmode)
        0:       c = (k == 4) ? 8'd1 : 8'd0;
        1:       c = 8'd1;
        2:       c = 8'h80;
        default: c = 8'($urandom);
      endcase
      kernel[k*DW +: DW] = {24'($urandom), c};
    end
  endtask

  // pmode: 0 raster ramp, 1 constant 10, 2 constant 255, 3 random
  task automatic send_pixels(input int n, input int pmode, input int duty);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      while (duty > 0 && $urandom_range(99, 0) < duty) tick(1'b0, 8'($urandom), 1'b0);
      case (pmode)
        0:       p = 8'((m_row * W + m_col) % 256);
        1:       p = 8'd10;
        2:       p = 8'd255;
        default: p = 8'($urandom);
      endcase
      tick(1'b1, p, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic check_counts(input string tag, input int res0, input int done0,
                              input int res_exp, input int done_exp);
    check({tag, "_results"}, 32'(n_res - res0), 32'(res_exp));
    check({tag, "_frame_done"}, 32'(n_done - done0), 32'(done_exp));
  endtask

  initial begin
    int r0, d0;
    n_checks = 0;
    n_errors = 0;
    n_res    = 0;
    n_done   = 0;
    cyc      = 0;
    reset    = 1'b0;
    kernel   = '0;
    pixel    = '0;
    pixel_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    do_reset();

    // identity ramp, then all-ones constant frame back-to-back
    r0 = n_res; d0 = n_done;
    set_kernel(0);
    send_pixels(W*H, 0, 0);
    set_kernel(1);
    send_pixels(W*H, 1, 0);
    drain(4);
    check_counts("b2b", r0, d0, 2*(W-2)*(H-2), 2);

    // most negative coefficients with saturated pixels
    r0 = n_res; d0 = n_done;
    set_kernel(2);
    send_pixels(W*H, 2, 0);
    drain(4);
    check("neg_last", 32'(last_data), 32'h000B8480);
    check_counts("neg", r0, d0, (W-2)*(H-2), 1);

    // identity ramp with 50% pixel_valid gaps
    r0 = n_res; d0 = n_done;
    set_kernel(0);
    send_pixels(W*H, 0, 50);
    drain(4);
    check_counts("gaps", r0, d0, (W-2)*(H-2), 1);

    // kernel rewritten mid-frame takes effect only on the next frame
    r0 = n_res; d0 = n_done;
    set_kernel(3);
    send_pixels(400, 3, 0);
    set_kernel(3);
    send_pixels(W*H - 400, 3, 20);
    send_pixels(W*H, 3, 0);
    drain(4);
    check_counts("kchg", r0, d0, 2*(W-2)*(H-2), 2);

    // clear at pixel 300, then a full frame
    set_kernel(3);
    send_pixels(300, 3, 0);
    tick(1'b1, 8'($urandom), 1'b1);
    r0 = n_res; d0 = n_done;
    drain(3);
    set_kernel(3);
    send_pixels(W*H, 3, 10);
    drain(4);
    check_counts("clear", r0, d0, (W-2)*(H-2), 1);

    // asynchronous reset at pixel 300, then a full frame
    set_kernel(3);
    send_pixels(300, 3, 0);
    do_reset();
    r0 = n_res; d0 = n_done;
    drain(3);
    set_kernel(3);
    send_pixels(W*H, 3, 0);
    drain(4);
    check_counts("reset", r0, d0, (W-2)*(H-2), 1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
